rr_burst_arb: RTL and testbench

RR_BURST_ARB -- requirements
Module: rr_burst_arb

---
 rtl/rr_pkg.sv | 9 +
 rtl/rr_burst_arb_if.sv | 24 ++
 rtl/rr_burst_arb_chk.sv | 24 ++
 rtl/rr_pick.sv | 30 +++
 rtl/rr_burst_arb.sv | 125 ++++++++++++
 tb/tb_rr_burst_arb.sv | 177 +++++++++++++++++
 6 files changed

// File: rtl/rr_pkg.sv
// Shared types for the round-robin burst arbiter.
package rr_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/rr_burst_arb_if.sv
// Requester-side handshake bundle of the round-robin burst arbiter.
interface rr_burst_arb_if #(
    parameter int N    = 10,
    parameter int logN = $clog2(N)
);
    logic [N-1:0]    req;
    logic [N-1:0]    req_last;
    logic            ready;
    logic [N-1:0]    gnt;
    logic [logN-1:0] gnt_id;
    logic            out_valid;
    logic            busy;
    logic            err_overrun;

    modport master (
        output req, req_last, ready,
        input  gnt, gnt_id, out_valid, busy, err_overrun
    );

    modport slave (
        input  req, req_last, ready,
        output gnt, gnt_id, out_valid, busy, err_overrun
    );
endinterface

// File: rtl/rr_burst_arb_chk.sv
// Property checker for grant encoding and grant stability of rr_burst_arb.
module rr_burst_arb_chk #(
    parameter int N    = 10,
    parameter int logN = $clog2(N)
) (
    input logic            clk,
    input logic            rst_n,
    input logic [N-1:0]    req,
    input logic [N-1:0]    gnt,
    input logic [logN-1:0] gnt_id,
    input logic            busy,
    input logic            out_valid,
    input logic            ready
);

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_busy:   assert property (@(posedge clk) disable iff (!rst_n) busy == (gnt != {N{1'b0}}));
    a_decode: assert property (@(posedge clk) disable iff (!rst_n) busy |-> (gnt == (N'(1'b1) << gnt_id)));
    a_valid:  assert property (@(posedge clk) disable iff (!rst_n) out_valid == (busy & req[gnt_id]));
    // Without an accepted beat there can be no release, so the grant must not move.
    a_hold:   assert property (@(posedge clk) disable iff (!rst_n)
                  ($past(busy) && !($past(out_valid) && $past(ready))) |-> (gnt == $past(gnt)));

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first asserted request after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N    = 10,
    parameter int logN = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [logN-1:0] ptr,
    output logic [N-1:0]    onehot,
    output logic [logN-1:0] index,
    output logic            any
);

    // Scan offsets 1..N from ptr; the first hit wins and later hits are ignored.
    always_comb begin
        int   idx_i;
        logic hit_s;
        any    = 1'b0;
        index  = {logN{1'b0}};
        idx_i  = 0;
        hit_s  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx_i = (int'(ptr) + k) % N;
            hit_s = ~any & req[logN'(idx_i)];
            index = hit_s ? logN'(idx_i) : index;
            any   = any | hit_s;
        end
        onehot = any ? (N'(1'b1) << index) : {N{1'b0}};
    end

endmodule

// File: rtl/rr_burst_arb.sv
// Round-robin burst arbiter: holds a grant for a whole burst, hands off with no bubble.
module rr_burst_arb
    import rr_pkg::*;
#(
    parameter int N         = 10,
    parameter int logN      = $clog2(N),
    parameter int MAX_BEATS = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_burst_arb_if.slave bus
);

    localparam int              CW      = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_BEATS);
    localparam logic [logN-1:0] LP_RST  = logN'(N - 1);

    state_e          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [logN-1:0] gnt_id_q, gnt_id_d;
    logic [logN-1:0] last_ptr_q, last_ptr_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
    logic            err_q, err_d;

    logic            busy_s, accept_s, is_last_s, cnt_hit_s, release_s;
    logic [CW-1:0]   cnt_inc_s;
    logic [logN-1:0] pick_ptr_s, pick_idx_s;
    logic [N-1:0]    pick_req_s, pick_oh_s;
    logic            pick_any_s;

    assign busy_s    = (state_q == BUSY);
    assign accept_s  = busy_s & bus.req[gnt_id_q] & bus.ready;
    assign is_last_s = bus.req_last[gnt_id_q];
    assign cnt_inc_s = beat_cnt_q + CW'(1'b1);
    assign cnt_hit_s = (cnt_inc_s == MAX_CNT);
    assign release_s = accept_s & (is_last_s | cnt_hit_s);

    // On release the owner is both the new pointer and masked out, so it goes last.
    assign pick_ptr_s = busy_s ? gnt_id_q : last_ptr_q;
    assign pick_req_s = release_s ? (bus.req & ~gnt_q) : bus.req;

    rr_pick #(
        .N    (N),
        .logN (logN)
    ) u_pick (
        .req    (pick_req_s),
        .ptr    (pick_ptr_s),
        .onehot (pick_oh_s),
        .index  (pick_idx_s),
        .any    (pick_any_s)
    );

    // Next-state, grant, beat counter and overrun flag.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        last_ptr_d = last_ptr_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    state_d  = BUSY;
                    gnt_d    = pick_oh_s;
                    gnt_id_d = pick_idx_s;
                end else begin
                    state_d  = IDLE;
                end
            end
            BUSY: begin
                if (release_s) begin
                    last_ptr_d = gnt_id_q;
                    beat_cnt_d = {CW{1'b0}};
                    err_d      = cnt_hit_s & ~is_last_s;
                    if (pick_any_s) begin
                        state_d  = BUSY;
                        gnt_d    = pick_oh_s;
                        gnt_id_d = pick_idx_s;
                    end else begin
                        state_d  = IDLE;
                        gnt_d    = {N{1'b0}};
                        gnt_id_d = {logN{1'b0}};
                    end
                end else if (accept_s) begin
                    beat_cnt_d = cnt_inc_s;
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
            end
            default: begin
                state_d    = IDLE;
                gnt_d      = {N{1'b0}};
                gnt_id_d   = {logN{1'b0}};
                beat_cnt_d = {CW{1'b0}};
            end
        endcase
    end

    // State registers; reset gives requester 0 first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= {N{1'b0}};
            gnt_id_q   <= {logN{1'b0}};
            last_ptr_q <= LP_RST;
            beat_cnt_q <= {CW{1'b0}};
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            last_ptr_q <= last_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.gnt_id      = gnt_id_q;
    assign bus.busy        = busy_s;
    assign bus.out_valid   = busy_s & bus.req[gnt_id_q];
    assign bus.err_overrun = err_q;

endmodule

// File: tb/tb_rr_burst_arb.sv
// Table-driven scoreboard bench for rr_burst_arb with N=4, MAX_BEATS=4.
module tb_rr_burst_arb;

    localparam int N    = 4;
    localparam int LOGN = 2;

    typedef struct {
        logic [3:0] req;
        logic [3:0] last;
        logic       ready;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       err;
        logic       ov;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    vec_t tbl[$];
    vec_t exp_q[$];

    rr_burst_arb_if #(.N(N), .logN(LOGN)) bus ();

    rr_burst_arb #(.N(N), .logN(LOGN), .MAX_BEATS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    rr_burst_arb_chk #(.N(N), .logN(LOGN)) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus.req),
        .gnt       (bus.gnt),
        .gnt_id    (bus.gnt_id),
        .busy      (bus.busy),
        .out_valid (bus.out_valid),
        .ready     (bus.ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic [3:0] l, input logic rd,
                       input logic [3:0] g, input logic [1:0] i,
                       input logic b, input logic e, input logic o);
        vec_t v;
        v.req = r; v.last = l; v.ready = rd;
        v.gnt = g; v.id = i; v.busy = b; v.err = e; v.ov = o;
        tbl.push_back(v);
    endtask

    // Drive one cycle of inputs, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        bus.req      = v.req;
        bus.req_last = v.last;
        bus.ready    = v.ready;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk($sformatf("v%0d.gnt", idx),    32'(bus.gnt),         32'(e.gnt));
        chk($sformatf("v%0d.gnt_id", idx), 32'(bus.gnt_id),      32'(e.id));
        chk($sformatf("v%0d.busy", idx),   32'(bus.busy),        32'(e.busy));
        chk($sformatf("v%0d.err", idx),    32'(bus.err_overrun), 32'(e.err));
        chk($sformatf("v%0d.ov", idx),     32'(bus.out_valid),   32'(e.ov));
    endtask

    initial begin
        vec_t v;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.req      = 4'b0000;
        bus.req_last = 4'b0000;
        bus.ready    = 1'b0;

        // Two-beat handoff 1 -> 3 with no bubble, then idle.
        add(4'b1010, 4'b1010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1);
        add(4'b1010, 4'b1010, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1);
        add(4'b1000, 4'b1000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        add(4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        // Requester 2 overruns: forced release after beat 4.
        add(4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
        add(4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
        add(4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
        add(4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
        add(4'b0100, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
        add(4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        // All requesting, single beats: starts after last_ptr=2, then rotates.
        add(4'b1111, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1);
        add(4'b1111, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
        add(4'b1111, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1);
        add(4'b1111, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
        add(4'b1111, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1);
        add(4'b1111, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
        add(4'b0001, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        // Requester 1, 3 beats with two stalled cycles; requester 2 waits then takes over.
        add(4'b0010, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1);
        add(4'b0010, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1);
        add(4'b0110, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1);
        add(4'b0110, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1);
        add(4'b0110, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1);
        add(4'b0110, 4'b0010, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
        add(4'b0100, 4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        // Requester 0 ends with req_last on exactly beat 4: no overrun.
        add(4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
        add(4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
        add(4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
        add(4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
        add(4'b0001, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst.gnt",    32'(bus.gnt),         32'h0);
        chk("rst.gnt_id", 32'(bus.gnt_id),      32'h0);
        chk("rst.busy",   32'(bus.busy),        32'h0);
        chk("rst.err",    32'(bus.err_overrun), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Reset in the middle of a requester-3 burst.
        v.req = 4'b1000; v.last = 4'b0000; v.ready = 1'b1;
        v.gnt = 4'b1000; v.id = 2'd3; v.busy = 1'b1; v.err = 1'b0; v.ov = 1'b1;
        apply(v, 100);
        apply(v, 101);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst.gnt",    32'(bus.gnt),         32'h0);
        chk("arst.gnt_id", 32'(bus.gnt_id),      32'h0);
        chk("arst.busy",   32'(bus.busy),        32'h0);
        chk("arst.err",    32'(bus.err_overrun), 32'h0);
        bus.req      = 4'b1111;
        bus.req_last = 4'b1111;
        @(posedge clk);
        #1;
        chk("arst_hold.gnt", 32'(bus.gnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst.gnt", 32'(bus.gnt), 32'h0);
        v.req = 4'b1111; v.last = 4'b1111; v.ready = 1'b1;
        v.gnt = 4'b0001; v.id = 2'd0; v.busy = 1'b1; v.err = 1'b0; v.ov = 1'b1;
        apply(v, 102);
        v.gnt = 4'b0010; v.id = 2'd1;
        apply(v, 103);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
